// File: rtl/pmu_mc.sv
// -----------------------------------------------------------------------------
// pmu_mc -- serial configuration frame receiver and per-chain distributor.
//
// Receives an LSB-first bitstream (qualified by en_i) made of one header word
// followed by N payload words, each optionally followed by a CRC-8 field
// (x^8+x^2+x+1, init 0, MSB-first on the wire). Every accepted payload word is
// re-serialized onto the selected configuration chain as WORD_W consecutive
// strobe cycles.
//
// Ports:
//   tck_i          sole clock, rising edge
//   rst_i          synchronous active-high reset
//   data_i         serial input bit, LSB first, valid when en_i=1
//   en_i           bit-valid qualifier; low pauses reception
//   checksum_en_i  CRC mode select, sampled on the first header bit
//   progclk_o      per-chain shift strobe, one pulse per delivered bit
//   data_o         per-chain serial data, valid with the matching strobe
//   data_ccff_i    per-chain readback tails
//   data_ccff_o    readback tail of the active chain, registered
//   flag_o_fpga    configuration complete (to fabric)
//   flag_o_jtag    frame finished, good or bad (to JTAG)
//   err_o          sticky error: CRC mismatch or illegal channel
// -----------------------------------------------------------------------------
module pmu_mc #(
  parameter int WORD_W = 64,
  parameter int CRC_W  = 8,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              tck_i,
  input  logic              rst_i,
  input  logic              data_i,
  input  logic              en_i,
  input  logic              checksum_en_i,
  output logic [NUM_CH-1:0] progclk_o,
  output logic [NUM_CH-1:0] data_o,
  input  logic [NUM_CH-1:0] data_ccff_i,
  output logic              data_ccff_o,
  output logic              flag_o_fpga,
  output logic              flag_o_jtag,
  output logic              err_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = $clog2(WORD_W + CRC_W + 1);
  localparam int SER_W = $clog2(WORD_W + 1);

  localparam logic [CRC_W-1:0] CRC_POLY   = CRC_W'(8'h07);
  localparam logic [BIT_W-1:0] DATA_BITS  = BIT_W'(WORD_W);
  localparam logic [BIT_W-1:0] LAST_PLAIN = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] LAST_CRC   = BIT_W'(WORD_W + CRC_W - 1);
  localparam logic [SER_W-1:0] SER_LOAD   = SER_W'(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_e;

  state_e              state_q,      state_d;
  logic [BIT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic [WORD_W-1:0]   shift_q,      shift_d;
  logic [CRC_W-1:0]    crc_q,        crc_d;
  logic [CRC_W-1:0]    rx_crc_q,     rx_crc_d;
  logic                crc_mode_q,   crc_mode_d;
  logic [CNT_W-1:0]    words_left_q, words_left_d;
  logic [CH_W-1:0]     ch_q,         ch_d;
  logic [WORD_W-1:0]   buf_q,        buf_d;
  logic [SER_W-1:0]    ser_cnt_q,    ser_cnt_d;
  logic [NUM_CH-1:0]   progclk_q,    progclk_d;
  logic [NUM_CH-1:0]   data_q,       data_d;
  logic                ccff_q,       ccff_d;
  logic                fpga_q,       fpga_d;
  logic                jtag_q,       jtag_d;
  logic                err_q,        err_d;

  // Receive-side decode of the current input bit.
  logic              rx_active;
  logic              crc_mode;
  logic              in_data;
  logic              word_end;
  logic              crc_fb;
  logic              crc_ok;
  logic [CRC_W-1:0]  rx_crc_full;
  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  hdr_n;
  logic [7:0]        hdr_ch;

  assign rx_active   = en_i && (state_q inside {S_IDLE, S_HEADER, S_PAYLOAD});
  // The first header bit arrives while still in IDLE, before the mode is latched.
  assign crc_mode    = (state_q == S_IDLE) ? checksum_en_i : crc_mode_q;
  assign in_data     = (bit_cnt_q < DATA_BITS);
  assign word_end    = rx_active && (bit_cnt_q == (crc_mode ? LAST_CRC : LAST_PLAIN));
  assign crc_fb      = crc_q[CRC_W-1] ^ data_i;
  assign rx_crc_full = {rx_crc_q[CRC_W-2:0], data_i};
  // On a CRC word the final bit is a CRC bit, so the data CRC is already final.
  assign crc_ok      = !crc_mode || (rx_crc_full == crc_q);
  // Complete word including the bit arriving this cycle (if it is a data bit).
  assign word        = in_data ? {data_i, shift_q[WORD_W-1:1]} : shift_q;
  assign hdr_n       = word[CNT_W-1:0];
  assign hdr_ch      = word[CNT_W+7:CNT_W];

  always_comb begin
    // NOTE: every *_d gets a default first so no path can infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    rx_crc_d     = rx_crc_q;
    crc_mode_d   = crc_mode_q;
    words_left_d = words_left_q;
    ch_d         = ch_q;
    buf_d        = buf_q;
    ser_cnt_d    = ser_cnt_q;
    progclk_d    = '0;
    data_d       = '0;
    ccff_d       = data_ccff_i[ch_q];
    fpga_d       = fpga_q;
    jtag_d       = jtag_q;
    err_d        = err_q;

    // Receive datapath: data bits shift in from the top so bit 0 ends at [0];
    // the CRC tail is collected MSB-first for comparison at word end.
    if (rx_active) begin
      if (in_data) begin
        shift_d = word;
        crc_d   = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
      end else begin
        rx_crc_d = rx_crc_full;
      end
      if (word_end) begin
        bit_cnt_d = '0;
        crc_d     = '0;
        rx_crc_d  = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end

    // Output serializer runs regardless of en_i or FSM state. A reload on the
    // same edge as the last bit gives back-to-back words with no gap.
    if (ser_cnt_q != '0) begin
      progclk_d[ch_q] = 1'b1;
      data_d[ch_q]    = buf_q[0];
      buf_d           = buf_q >> 1;
      ser_cnt_d       = ser_cnt_q - SER_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d    = S_HEADER;
          crc_mode_d = checksum_en_i;
          fpga_d     = 1'b0;
          jtag_d     = 1'b0;
        end
      end
      S_HEADER: begin
        if (word_end) begin
          if (!crc_ok || (int'(hdr_ch) >= NUM_CH)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            jtag_d  = 1'b1;
            fpga_d  = 1'b0;
          end else begin
            ch_d         = hdr_ch[CH_W-1:0];
            words_left_d = hdr_n;
            if (hdr_n == '0) begin
              state_d = S_DONE;
              fpga_d  = 1'b1;
              jtag_d  = 1'b1;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (word_end) begin
          if (!crc_ok) begin
            // Bad word is dropped; any word already shifting still completes.
            state_d = S_ERROR;
            err_d   = 1'b1;
            jtag_d  = 1'b1;
            fpga_d  = 1'b0;
          end else begin
            buf_d        = word;
            ser_cnt_d    = SER_LOAD;
            words_left_d = words_left_q - CNT_W'(1);
            if (words_left_q == CNT_W'(1)) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Counter hits zero on the cycle the last strobe is visible.
        if (ser_cnt_q == '0) begin
          state_d = S_DONE;
          fpga_d  = 1'b1;
          jtag_d  = 1'b1;
        end
      end
      S_DONE, S_ERROR: begin
        if (!en_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      crc_q        <= '0;
      rx_crc_q     <= '0;
      crc_mode_q   <= 1'b0;
      words_left_q <= '0;
      ch_q         <= '0;
      // NOTE: the word buffer is cleared on reset so an aborted word can never
      // leak onto a chain after reset.
      buf_q        <= '0;
      ser_cnt_q    <= '0;
      progclk_q    <= '0;
      data_q       <= '0;
      ccff_q       <= 1'b0;
      fpga_q       <= 1'b0;
      jtag_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      rx_crc_q     <= rx_crc_d;
      crc_mode_q   <= crc_mode_d;
      words_left_q <= words_left_d;
      ch_q         <= ch_d;
      buf_q        <= buf_d;
      ser_cnt_q    <= ser_cnt_d;
      progclk_q    <= progclk_d;
      data_q       <= data_d;
      ccff_q       <= ccff_d;
      fpga_q       <= fpga_d;
      jtag_q       <= jtag_d;
      err_q        <= err_d;
    end
  end

  assign progclk_o   = progclk_q;
  assign data_o      = data_q;
  assign data_ccff_o = ccff_q;
  assign flag_o_fpga = fpga_q;
  assign flag_o_jtag = jtag_q;
  assign err_o       = err_q;

endmodule
